// File: rtl/imem_program_loader.sv
// imem_program_loader
// Streams a program image into instruction memory over a valid/ready port.
// The datapath is held in reset until the image is loaded. After the final
// write, the datapath reset stays asserted for a hold window, then it is
// released. Only the loader writes instruction memory; the datapath only
// reads it.
//
// Optional feature (macro IMEM_LOADER_CHECKSUM_EN):
//   The loader keeps a wrap-around sum of the program words. After the last
//   word it accepts one extra checksum beat, which is not written to memory.
//   If the beat does not match the sum, the loader halts and err_checksum is
//   set. Without the macro there is no CHECK state and err_checksum is 0.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   in_valid     source has a word
//   in_data      program word
//   in_last      marks the final program word
//   in_ready     loader accepts a word this cycle (decoded from state)
//   reload       pulse to restart loading; honoured in RUN or HALT only
//   imem_we      instruction memory write enable (registered)
//   imem_addr    instruction memory write address (registered)
//   imem_wdata   instruction memory write data (registered)
//   cpu_rst      active-high reset to the datapath
//   done         program loaded and datapath running
//   word_count   number of program words written
//   err_overflow image filled the memory without in_last
//   err_checksum checksum beat did not match the sum of the words
module imem_program_loader #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int HOLD_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_overflow,
  output logic              err_checksum
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, HOLD, RUN, HALT} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, HALT} state_t;
`endif

  state_t            state, next_state;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        hold_cnt;
  logic              accept;
  logic              load_accept;
  logic              at_top;
  logic              restart;

  // The top address ends the image even when in_last is missing.
  assign at_top      = (addr == {ADDR_W{1'b1}});
  assign accept      = in_valid & in_ready;
  assign load_accept = accept & (state == LOAD);
  assign restart     = reload & ((state == RUN) | (state == HALT));

  // All of these are decoded from the registered state, so there is no
  // combinational path from in_valid to in_ready.
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign in_ready = (state == LOAD) | (state == CHECK);
`else
  assign in_ready = (state == LOAD);
`endif
  assign done    = (state == RUN);
  assign cpu_rst = (state != RUN);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  logic              sum_ok;
  assign sum_ok = (in_data == sum);
`else
  assign err_checksum = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic. The overflow word is treated as the last word.
  // HOLD stays in place until the counter reaches HOLD_CYC. This releases
  // the datapath HOLD_CYC edges after the edge that performs the final write.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: next_state = LOAD;
      LOAD: begin
        if (load_accept && (in_last || at_top)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          next_state = CHECK;
`else
          next_state = HOLD;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: if (accept) next_state = sum_ok ? HOLD : HALT;
`endif
      HOLD: if (hold_cnt == 8'(HOLD_CYC)) next_state = RUN;
      RUN:  if (reload) next_state = LOAD;
      HALT: if (reload) next_state = LOAD;
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers: write port, address, count, hold counter, flags.
  // A reload from RUN or HALT clears everything needed to start a new image.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      addr         <= '0;
      word_count   <= '0;
      hold_cnt     <= '0;
      err_overflow <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum          <= '0;
      err_checksum <= 1'b0;
`endif
    end else begin
      imem_we  <= load_accept;
      hold_cnt <= (state == HOLD) ? hold_cnt + 8'd1 : 8'd0;
      if (load_accept) begin
        imem_addr  <= addr;
        imem_wdata <= in_data;
        word_count <= word_count + (ADDR_W+1)'(1);
        if (!at_top)
          addr <= addr + ADDR_W'(1);
        else if (!in_last)
          err_overflow <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum <= sum + in_data;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (accept && (state == CHECK) && !sum_ok)
        err_checksum <= 1'b1;
`endif
      if (restart) begin
        addr         <= '0;
        word_count   <= '0;
        err_overflow <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum          <= '0;
        err_checksum <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
`timescale 1ns/1ps
// Testbench for imem_program_loader.
// Program images come from directed tables and from $urandom. The bench model
// is a plain list of the words in each image. It expects these results:
//   - word i is written at address i, in the cycle after its accept;
//   - word_count equals the number of words;
//   - the datapath is released 1+HOLD cycles after the final accepted beat.
module tb_imem_program_loader;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int HOLD   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              reload = 1'b0;
  logic              in_ready, imem_we, cpu_rst, done, err_overflow, err_checksum;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic [ADDR_W:0]   word_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int readyDrops = 0;

  logic [DATA_W-1:0] img[$];
  int                wAddr[$];
  logic [DATA_W-1:0] wData[$];
  int                wEdge[$];

  imem_program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOLD_CYC(HOLD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .reload(reload),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .done(done), .word_count(word_count),
    .err_overflow(err_overflow), .err_checksum(err_checksum)
  );

  always #5 clk = ~clk;

  // Edge index: a process that resumes on a posedge reads the index of that
  // edge. At the following negedge, cyc-1 is the same index.
  always @(posedge clk) cyc <= cyc + 1;

  // Log every write. The log records the edge at which the write port was
  // loaded.
  always @(negedge clk) begin
    if (rst && imem_we) begin
      wAddr.push_back(int'(imem_addr));
      wData.push_back(imem_wdata);
      wEdge.push_back(cyc - 1);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_in_ready"}, in_ready, 0);
    checkOutput({pfx, "_imem_we"}, imem_we, 0);
    checkOutput({pfx, "_imem_addr"}, imem_addr, 0);
    checkOutput({pfx, "_cpu_rst"}, cpu_rst, 1);
    checkOutput({pfx, "_done"}, done, 0);
    checkOutput({pfx, "_word_count"}, word_count, 0);
    checkOutput({pfx, "_err_overflow"}, err_overflow, 0);
    checkOutput({pfx, "_err_checksum"}, err_checksum, 0);
  endtask

  // Present one beat after gapCnt idle cycles. Return the edge at which the
  // beat is accepted. in_ready must stay high during LOAD, including the gap
  // cycles.
  task automatic applyStimulus(input logic [DATA_W-1:0] d, input logic l, input int gapCnt,
                               output int edgeIdx);
    for (int g = 0; g < gapCnt; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (!in_ready) readyDrops++;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    if (!in_ready) readyDrops++;
    @(posedge clk);
    edgeIdx = cyc;
  endtask

  task automatic reloadPulse(input string pfx);
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    checkOutput({pfx, "_cpu_rst"}, cpu_rst, 1);
    checkOutput({pfx, "_done"}, done, 0);
    checkOutput({pfx, "_ready"}, in_ready, 1);
    checkOutput({pfx, "_count_clr"}, word_count, 0);
  endtask

  // Send img[0..n-1], then check the write log and the release timing
  // against the model.
  task automatic runImage(input string pfx, input int n, input bit useLast,
                          input int gapLo, input int gapHi);
    int accEdge[$];
    int e;
    int lastEdge;
    int doneEdge;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum = '0;
`endif
    wAddr.delete(); wData.delete(); wEdge.delete();
    readyDrops = 0;
    lastEdge = -100;
    for (int k = 0; k < 10 && !in_ready; k++) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      applyStimulus(img[i], useLast && (i == n - 1), int'($urandom_range(gapHi, gapLo)), e);
      accEdge.push_back(e);
      lastEdge = e;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum += img[i];
`endif
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    applyStimulus(sum, 1'b0, 0, e);
    lastEdge = e;
`endif
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int k = 0; k < 300 && !done; k++) @(negedge clk);
    doneEdge = done ? cyc - 1 : -1;
    checkOutput({pfx, "_write_count"}, wAddr.size(), n);
    for (int i = 0; i < n && i < wAddr.size(); i++) begin
      checkOutput({pfx, "_waddr"}, wAddr[i], i);
      checkOutput({pfx, "_wdata"}, wData[i], img[i]);
      checkOutput({pfx, "_wlatency"}, wEdge[i], accEdge[i]);
    end
    checkOutput({pfx, "_word_count"}, word_count, n);
    checkOutput({pfx, "_err_overflow"}, err_overflow, !useLast);
    checkOutput({pfx, "_err_checksum"}, err_checksum, 0);
    checkOutput({pfx, "_release_edge"}, doneEdge, lastEdge + 1 + HOLD);
    checkOutput({pfx, "_cpu_rst"}, cpu_rst, 0);
    checkOutput({pfx, "_ready_drops"}, readyDrops, 0);
  endtask

  initial begin
    int e;
    string tag;
    $display("[TB] start");
    #12;
    checkResetValues("por");
    checkOutput("por_wdata", imem_wdata, 0);
    @(negedge clk);
    rst = 1'b1;

    // Directed image at 1 word/cycle, then the same image with gaps.
    img = '{32'h20080005, 32'h20090003, 32'h01095020};
    runImage("t1", 3, 1, 0, 0);
    reloadPulse("t2_reload");
    runImage("t2", 3, 1, 1, 1);

    // Full memory without in_last.
    reloadPulse("t3_reload");
    img.delete();
    for (int i = 0; i < (1 << ADDR_W); i++) img.push_back($urandom);
    runImage("t3", 1 << ADDR_W, 0, 0, 0);

    // Asynchronous reset in the middle of a 5-word image, then a 2-word image.
    reloadPulse("t4_reload");
    applyStimulus($urandom, 1'b0, 0, e);
    applyStimulus($urandom, 1'b0, 0, e);
    #2;
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    checkResetValues("t4_async");
    @(negedge clk);
    rst = 1'b1;
    img = '{$urandom, $urandom};
    runImage("t4", 2, 1, 0, 0);

    // Reload from RUN with a single word.
    reloadPulse("t5_reload");
    img = '{32'hDEADBEEF};
    runImage("t5", 1, 1, 0, 0);

    // Random images.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(12, 1));
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom);
      tag = $sformatf("rnd%0d", r);
      reloadPulse({tag, "_reload"});
      runImage(tag, n, 1, 0, 2);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Matching checksum beat (runImage appends the sum of the words).
    reloadPulse("cs_ok_reload");
    img = '{32'd1, 32'd2};
    runImage("cs_ok", 2, 1, 0, 0);
    // Wrong checksum beat: the loader halts.
    reloadPulse("cs_bad_reload");
    applyStimulus(32'd1, 1'b0, 0, e);
    applyStimulus(32'd2, 1'b1, 0, e);
    applyStimulus(32'd4, 1'b0, 0, e);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (HOLD + 4) @(negedge clk);
    checkOutput("cs_bad_err", err_checksum, 1);
    checkOutput("cs_bad_cpu_rst", cpu_rst, 1);
    checkOutput("cs_bad_done", done, 0);
    checkOutput("cs_bad_ready", in_ready, 0);
    reloadPulse("cs_recover");
    checkOutput("cs_recover_err", err_checksum, 0);
    img = '{32'h12345678};
    runImage("cs_after", 1, 1, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
